// File: rtl/refill_line_buffer.sv
// Refill line buffer: reorders one WRAP-burst refill into line order, forwards the
// critical word early, tracks per-word arrival and holds the assembled line until acked.
module refill_line_buffer #(
  parameter int LINE_WORDS = 16,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [31:0]                  i_start_addr,
  input  logic                         i_beat_valid,
  input  logic [DATA_W-1:0]            i_beat_data,
  input  logic                         i_beat_last,
  output logic                         o_busy,
  output logic                         o_crit_valid,
  output logic [DATA_W-1:0]            o_crit_data,
  output logic [LINE_WORDS-1:0]        o_word_valid,
  output logic                         o_line_valid,
  output logic [31:0]                  o_line_addr,
  output logic [LINE_WORDS*DATA_W-1:0] o_line_data,
  input  logic                         i_line_ack,
  output logic                         o_err
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(LINE_WORDS - 1);
  localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  state_t                         state;
  logic [IDX_W-1:0]               ptr;
  logic [IDX_W-1:0]               cnt;
  logic [LINE_WORDS-1:0]          word_valid;
  logic [LINE_WORDS*DATA_W-1:0]   line_data;
  logic [DATA_W-1:0]              crit_data;
  logic [31:0]                    line_addr;
  logic                           crit_valid;
  logic                           line_valid;
  logic                           err;
  logic                           take_start;

  // A start is only taken from IDLE, or from HOLD when the line is acked in the same cycle.
  assign take_start = i_start && ((state == IDLE) || ((state == HOLD) && i_line_ack));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      word_valid <= '0;
      line_data  <= '0;
      crit_data  <= '0;
      line_addr  <= '0;
      crit_valid <= 1'b0;
      line_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      crit_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (i_beat_valid) err <= 1'b1;
        end
        FILL: begin
          if (i_beat_valid) begin
            if (i_beat_last && (cnt != LAST_CNT)) begin
              err        <= 1'b1;
              word_valid <= '0;
              state      <= IDLE;
            end else if (!i_beat_last && (cnt == LAST_CNT)) begin
              err        <= 1'b1;
              word_valid <= '0;
              state      <= DRAIN;
            end else begin
              line_data[int'(ptr)*DATA_W +: DATA_W] <= i_beat_data;
              word_valid[ptr] <= 1'b1;
              ptr             <= ptr + 1'b1;
              cnt             <= cnt + 1'b1;
              if (cnt == '0) begin
                crit_data  <= i_beat_data;
                crit_valid <= 1'b1;
              end
              if (i_beat_last) begin
                line_valid <= 1'b1;
                state      <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (i_beat_valid) err <= 1'b1;
          if (i_line_ack) begin
            line_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (i_beat_valid && i_beat_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Start overrides the IDLE transition from an acked HOLD for back-to-back refills.
      if (take_start) begin
        line_addr  <= i_start_addr & ~LINE_MASK;
        ptr        <= i_start_addr[IDX_W+1:2];
        cnt        <= '0;
        word_valid <= '0;
        state      <= FILL;
      end
    end
  end

  assign o_busy       = (state != IDLE);
  assign o_crit_valid = crit_valid;
  assign o_crit_data  = crit_data;
  assign o_word_valid = word_valid;
  assign o_line_valid = line_valid;
  assign o_line_addr  = line_addr;
  assign o_line_data  = line_data;
  assign o_err        = err;

endmodule

// File: tb/tb_refill_line_buffer.sv
// Scoreboard bench for refill_line_buffer: stimulus pushes expected critical words, lines
// and error pulses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_refill_line_buffer;
  localparam int LW = 16;
  localparam int DW = 32;
  typedef logic [LW*DW-1:0] wide_t;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic [31:0]   i_start_addr = '0;
  logic          i_beat_valid = 1'b0;
  logic [DW-1:0] i_beat_data = '0;
  logic          i_beat_last = 1'b0;
  logic          i_line_ack = 1'b0;
  logic          o_busy, o_crit_valid, o_line_valid, o_err;
  logic [DW-1:0] o_crit_data;
  logic [LW-1:0] o_word_valid;
  logic [31:0]   o_line_addr;
  wide_t         o_line_data;

  always #5 i_clk = ~i_clk;

  refill_line_buffer #(.LINE_WORDS(LW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_beat_valid(i_beat_valid), .i_beat_data(i_beat_data), .i_beat_last(i_beat_last),
    .o_busy(o_busy), .o_crit_valid(o_crit_valid), .o_crit_data(o_crit_data),
    .o_word_valid(o_word_valid), .o_line_valid(o_line_valid), .o_line_addr(o_line_addr),
    .o_line_data(o_line_data), .i_line_ack(i_line_ack), .o_err(o_err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] crit_q[$];
  logic [31:0] laddr_q[$];
  wide_t       ldata_q[$];
  bit          err_q[$];

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic wide_t mk_line(input int sw, input logic [31:0] v0);
    wide_t r;
    r = '0;
    for (int k = 0; k < LW; k++) r[((sw + k) % LW)*DW +: DW] = v0 + 32'(k);
    return r;
  endfunction

  // Monitor
  logic        prev_lv = 1'b0;
  logic [31:0] cur_addr = '0;
  wide_t       cur_data = '0;
  always @(negedge i_clk) begin
    if (o_crit_valid) begin
      if (crit_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL crit_unexpected: got %0h expected no pulse", o_crit_data);
      end else chk("crit_data", wide_t'(o_crit_data), wide_t'(crit_q.pop_front()));
    end
    if (o_line_valid && !prev_lv) begin
      if (laddr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL line_unexpected: got addr %0h expected no line", o_line_addr);
      end else begin
        cur_addr = laddr_q.pop_front();
        cur_data = ldata_q.pop_front();
        chk("line_addr", wide_t'(o_line_addr), wide_t'(cur_addr));
        chk("line_data", o_line_data, cur_data);
      end
    end else if (o_line_valid && prev_lv) begin
      chk("line_hold", o_line_data, cur_data);
    end
    prev_lv = o_line_valid;
    if (o_err) begin
      tests++;
      if (err_q.size() == 0) begin
        fails++;
        $display("FAIL err_unexpected: got 1 expected 0");
      end else void'(err_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a);
    i_start = 1'b1; i_start_addr = a;
    tick();
    i_start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input bit l);
    i_beat_valid = 1'b1; i_beat_data = d; i_beat_last = l;
    tick();
    i_beat_valid = 1'b0; i_beat_last = 1'b0;
  endtask

  task automatic ack();
    i_line_ack = 1'b1;
    tick();
    i_line_ack = 1'b0;
  endtask

  logic [15:0] mask_tbl [4] = '{16'h2000, 16'h6000, 16'hE000, 16'hE001};

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_busy", wide_t'(o_busy), 0);
    chk("rst_word_valid", wide_t'(o_word_valid), 0);
    chk("rst_line_valid", wide_t'(o_line_valid), 0);
    chk("rst_line_data", o_line_data, 0);
    i_rst = 1'b0;
    tick();

    // 1: aligned refill
    crit_q.push_back(32'hA0);
    laddr_q.push_back(32'h1000_0000); ldata_q.push_back(mk_line(0, 32'hA0));
    start(32'h1000_0000);
    chk("t1_busy", wide_t'(o_busy), 1);
    chk("t1_addr", wide_t'(o_line_addr), wide_t'(32'h1000_0000));
    for (int i = 0; i < LW; i++) beat(32'hA0 + 32'(i), i == LW-1);
    chk("t1_line_valid", wide_t'(o_line_valid), 1);
    chk("t1_word15", wide_t'(o_line_data[15*DW +: DW]), wide_t'(32'hAF));
    ack();
    chk("t1_after_ack_lv", wide_t'(o_line_valid), 0);
    chk("t1_after_ack_busy", wide_t'(o_busy), 0);

    // 2: wrapped refill from word 13, then 3: hold for 5 cycles
    crit_q.push_back(32'hD0);
    laddr_q.push_back(32'h2000_0000); ldata_q.push_back(mk_line(13, 32'hD0));
    start(32'h2000_0034);
    chk("t2_addr", wide_t'(o_line_addr), wide_t'(32'h2000_0000));
    for (int i = 0; i < LW; i++) begin
      beat(32'hD0 + 32'(i), i == LW-1);
      if (i < 4) chk("t2_mask", wide_t'(o_word_valid), wide_t'(mask_tbl[i]));
    end
    chk("t2_word13", wide_t'(o_line_data[13*DW +: DW]), wide_t'(32'hD0));
    chk("t2_word15", wide_t'(o_line_data[15*DW +: DW]), wide_t'(32'hD2));
    chk("t2_word0", wide_t'(o_line_data[0 +: DW]), wide_t'(32'hD3));
    chk("t2_word12", wide_t'(o_line_data[12*DW +: DW]), wide_t'(32'hDF));
    chk("t2_full_mask", wide_t'(o_word_valid), wide_t'(16'hFFFF));
    repeat (5) tick();
    chk("t3_hold_lv", wide_t'(o_line_valid), 1);

    // 3: ack with start, back-to-back refill
    crit_q.push_back(32'h30);
    laddr_q.push_back(32'h3000_0000); ldata_q.push_back(mk_line(0, 32'h30));
    i_line_ack = 1'b1;
    start(32'h3000_0000);
    i_line_ack = 1'b0;
    chk("t3_busy", wide_t'(o_busy), 1);
    chk("t3_lv", wide_t'(o_line_valid), 0);
    chk("t3_mask", wide_t'(o_word_valid), 0);
    chk("t3_addr", wide_t'(o_line_addr), wide_t'(32'h3000_0000));
    for (int i = 0; i < LW; i++) beat(32'h30 + 32'(i), i == LW-1);
    chk("t3_line_valid", wide_t'(o_line_valid), 1);
    ack();

    // 4: short burst
    crit_q.push_back(32'h50);
    err_q.push_back(1'b1);
    start(32'h4000_0000);
    for (int i = 0; i < 8; i++) beat(32'h50 + 32'(i), i == 7);
    chk("t4_err", wide_t'(o_err), 1);
    chk("t4_busy", wide_t'(o_busy), 0);
    chk("t4_mask", wide_t'(o_word_valid), 0);
    tick();
    chk("t4_err_single", wide_t'(o_err), 0);
    chk("t4_lv", wide_t'(o_line_valid), 0);

    // 5: long burst, then a stray beat in IDLE
    crit_q.push_back(32'h60);
    err_q.push_back(1'b1);
    start(32'h5000_0000);
    for (int i = 0; i < 18; i++) begin
      beat(32'h60 + 32'(i), i == 17);
      if (i == 15) begin
        chk("t5_err", wide_t'(o_err), 1);
        chk("t5_drain_busy", wide_t'(o_busy), 1);
      end
      if (i == 16) chk("t5_drop_noerr", wide_t'(o_err), 0);
    end
    chk("t5_idle", wide_t'(o_busy), 0);
    chk("t5_lv", wide_t'(o_line_valid), 0);
    err_q.push_back(1'b1);
    beat(32'hEE, 1'b0);
    chk("t5_stray_err", wide_t'(o_err), 1);
    chk("t5_stray_idle", wide_t'(o_busy), 0);

    // 6: reset mid-fill, then a full wrapped refill from word 2
    crit_q.push_back(32'h70);
    start(32'h6000_0000);
    for (int i = 0; i < 7; i++) beat(32'h70 + 32'(i), 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t6_busy", wide_t'(o_busy), 0);
    chk("t6_crit_data", wide_t'(o_crit_data), 0);
    chk("t6_mask", wide_t'(o_word_valid), 0);
    chk("t6_addr", wide_t'(o_line_addr), 0);
    chk("t6_data", o_line_data, 0);
    chk("t6_err", wide_t'(o_err), 0);
    crit_q.push_back(32'h80);
    laddr_q.push_back(32'h7000_0000); ldata_q.push_back(mk_line(2, 32'h80));
    start(32'h7000_0008);
    for (int i = 0; i < LW; i++) beat(32'h80 + 32'(i), i == LW-1);
    chk("t6_line_valid", wide_t'(o_line_valid), 1);
    ack();
    chk("t6_idle", wide_t'(o_busy), 0);

    repeat (3) tick();
    chk("crit_q_drained", wide_t'(crit_q.size()), 0);
    chk("line_q_drained", wide_t'(laddr_q.size()), 0);
    chk("err_q_drained", wide_t'(err_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
